// File: rtl/manchester_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// manchester_tx_ctrl_if
// Upstream word handshake for the Manchester frame transmit controller.
//   in_data  : payload word (source -> controller)
//   in_valid : payload available (source -> controller)
//   in_ready : controller can accept a word (controller -> source)
// master = word source, slave = controller.
// ---------------------------------------------------------------------------
interface manchester_tx_ctrl_if #(
  parameter int DATA_W = 23
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/manchester_tx_ctrl.sv
// ---------------------------------------------------------------------------
// manchester_tx_ctrl
// Frame-level Manchester transmitter. Latches one word per frame, keeps its
// Manchester image (1 -> "10", 0 -> "01", MSB first) on coded_data and
// serialises SYNC (111000), DATA (2*DATA_W half-bits) and GAP (GAP_HB idle
// half-bits) onto line_out, each half-bit held DIV clock cycles.
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low reset
//   up         : word handshake (in_data / in_valid / in_ready), slave side
//   abort      : terminate current frame (honoured in SYNC/DATA only)
//   coded_data : Manchester image of the last accepted word
//   line_out   : serial half-bit stream
//   line_en    : high while SYNC or DATA symbols are driven
//   busy       : frame in progress
//   done       : one-cycle pulse, normal frame completion
//   aborted    : one-cycle pulse, aborted frame completion
// All outputs are registered.
// ---------------------------------------------------------------------------
module manchester_tx_ctrl #(
  parameter int DATA_W = 23,
  parameter int DIV    = 1,
  parameter int GAP_HB = 4
) (
  input  logic                clk,
  input  logic                reset,
  manchester_tx_ctrl_if.slave up,
  input  logic                abort,
  output logic [2*DATA_W-1:0] coded_data,
  output logic                line_out,
  output logic                line_en,
  output logic                busy,
  output logic                done,
  output logic                aborted
);
  localparam int SYNC_HB = 6;
  localparam int DATA_HB = 2 * DATA_W;
  localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_MAX = (DATA_HB > GAP_HB) ? DATA_HB : GAP_HB;
  localparam int IDX_W   = $clog2(((IDX_MAX > SYNC_HB) ? IDX_MAX : SYNC_HB) + 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_t;

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [IDX_W-1:0]    r_idx, w_idx_next;
  logic                r_aborting, w_aborting_next;
  logic [DATA_HB-1:0]  r_coded, w_coded_word, w_coded_next;
  logic                r_in_ready, r_line_out, r_line_en, r_busy, r_done, r_aborted;
  logic                w_line_out_next, w_line_en_next, w_done_next, w_aborted_next;
  logic [IDX_W-1:0]    w_data_pos;
  logic                w_accept, w_tick, w_frame_end;

  // Manchester image of the word currently offered upstream
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_code
    assign w_coded_word[2*gi+1:2*gi] = up.in_data[gi] ? 2'b10 : 2'b01;
  end

  assign w_accept    = (r_state == S_IDLE) && up.in_valid && r_in_ready;
  assign w_tick      = (r_cnt == CNT_W'(DIV - 1));
  assign w_frame_end = (r_state == S_GAP) && w_tick && (r_idx == IDX_W'(GAP_HB - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_aborting <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_idx      <= w_idx_next;
      r_aborting <= w_aborting_next;
    end
  end

  // Next-state logic; abort is checked before the symbol boundary so it wins
  // even on the last DATA half-bit.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_idx_next      = r_idx;
    w_aborting_next = r_aborting;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next    = S_SYNC;
          w_cnt_next      = '0;
          w_idx_next      = '0;
          w_aborting_next = 1'b0;
        end
      end
      S_SYNC, S_DATA: begin
        if (abort) begin
          w_state_next    = S_GAP;
          w_cnt_next      = '0;
          w_idx_next      = '0;
          w_aborting_next = 1'b1;
        end else if (w_tick) begin
          w_cnt_next = '0;
          if (r_state == S_SYNC && r_idx == IDX_W'(SYNC_HB - 1)) begin
            w_state_next = S_DATA;
            w_idx_next   = '0;
          end else if (r_state == S_DATA && r_idx == IDX_W'(DATA_HB - 1)) begin
            w_state_next = S_GAP;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (w_tick) begin
          w_cnt_next = '0;
          if (w_frame_end) begin
            w_state_next = S_IDLE;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: next values derived from the next state so the registered
  // outputs line up with the state they describe.
  assign w_data_pos = IDX_W'(DATA_HB - 1) - w_idx_next;

  always_comb begin
    w_coded_next    = w_accept ? w_coded_word : r_coded;
    w_line_en_next  = (w_state_next == S_SYNC) || (w_state_next == S_DATA);
    w_line_out_next = 1'b0;
    if (w_state_next == S_SYNC) begin
      // SYNC pattern 111000: deliberate Manchester violation
      w_line_out_next = (w_idx_next < IDX_W'(3));
    end else if (w_state_next == S_DATA) begin
      w_line_out_next = w_coded_next[w_data_pos];
    end
    w_done_next    = w_frame_end && !r_aborting;
    w_aborted_next = w_frame_end && r_aborting;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_coded    <= '0;
      r_in_ready <= 1'b0;
      r_line_out <= 1'b0;
      r_line_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_coded    <= w_coded_next;
      r_in_ready <= (w_state_next == S_IDLE);
      r_line_out <= w_line_out_next;
      r_line_en  <= w_line_en_next;
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= w_done_next;
      r_aborted  <= w_aborted_next;
    end
  end

  assign up.in_ready = r_in_ready;
  assign coded_data  = r_coded;
  assign line_out    = r_line_out;
  assign line_en     = r_line_en;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
endmodule

// File: doc/manchester_tx_ctrl.md
Name: manchester_tx_ctrl

Overview:
- Frame-level transmit controller for the Manchester line coder.
- Accepts one DATA_W-bit word per frame over a valid/ready handshake and latches its full Manchester-coded image (bit 1 -> "10", bit 0 -> "01", data MSB first).
- Sequences SYNC, DATA and GAP phases onto a serial line at a programmable half-bit rate.
- Reports completion or abort to the upstream source and the downstream decoder.

Parameters:
- DATA_W, 23: payload width in bits.
- DIV, 1: clock cycles per half-bit symbol (>=1).
- GAP_HB, 4: idle half-bits after each frame (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_data  input  DATA_W  payload word.
- in_valid  input  1  payload available.
- in_ready  output  1  controller can accept a word.
- abort  input  1  request to terminate the current frame.
- coded_data  output  2*DATA_W  Manchester image of the last accepted word.
- line_out  output  1  serial half-bit symbol stream.
- line_en  output  1  high while SYNC or DATA symbols are driven.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse on normal frame completion.
- aborted  output  1  one-cycle pulse on aborted frame completion.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; in_ready=0 during reset, 1 from the first cycle after release. line_out=0, line_en=0, coded_data=0, busy=0, done=0, aborted=0. Reset overrides every other input and any state.
- Registered outputs only; no combinational path from inputs to outputs.
- Accept: in IDLE, in_valid&&in_ready at an edge.
  - coded_data[2i+1:2i] <= in_data[i] ? 2'b10 : 2'b01.
  - Next state SYNC; in_ready=0, busy=1 from the next cycle.
  - in_valid outside IDLE is ignored and has no side effects.
- Half-bit timer: counter 0..DIV-1. A symbol advances when the counter wraps. Every symbol is held exactly DIV cycles.
- SYNC: 6 half-bits 1,1,1,0,0,0 (a deliberate Manchester violation used as the frame marker); line_en=1.
- DATA: 2*DATA_W half-bits = coded_data[2*DATA_W-1] down to [0]; line_en=1. Index wraps only at the frame end; no reuse.
- GAP: GAP_HB half-bits with line_out=0, line_en=0.
- Frame end: at the last GAP symbol boundary, go to IDLE. Register done=1 for exactly one cycle; in_ready=1 and busy=0 in the same cycle.
- First SYNC symbol appears the cycle after the accept edge. done is high in the cycle after edge (6+2*DATA_W+GAP_HB)*DIV counted from the accept edge.
- Back-to-back: a word offered with in_valid in the done cycle is accepted at that edge. The minimum frame period is (6+2*DATA_W+GAP_HB)*DIV+1 cycles.
- Abort: abort=1 sampled at an edge in SYNC or DATA.
  - Enter GAP on the next cycle: line_en=0, line_out=0, timer restarted, full GAP_HB half-bits.
  - At the end of GAP, pulse aborted (not done).
  - abort in IDLE or GAP is ignored. If abort and the last DATA symbol boundary coincide, abort wins.
- coded_data holds its value after a frame or abort until the next accept.

Test Plan:
- Reset then release, no stimulus.
  -> in_ready=1 one cycle after release; line_en=0, busy=0, coded_data=0 steady for 100 cycles.
- DIV=1, GAP_HB=4, in_data=23'd8200434 (23'b11111010010000011110010).
  -> coded_data=46'b1010101010011001011001010101011010101001011001 one cycle after accept.
  -> line_out reads 111000 followed by those 46 bits.
  -> line_en high for 52 cycles; done high in cycle 56 after accept.
- Same word with DIV=3.
  -> every symbol held 3 cycles; done at cycle 168; feeding line_out into the decoder recovers result=8200434.
- Two words back-to-back (8200434, then 23'h000001) with in_valid held high.
  -> second accept at the done edge; frames 57 cycles apart.
  -> second coded_data = 21 repetitions of 2'b01, then 2'b01, 2'b10.
- abort pulsed on DATA symbol 10.
  -> line_en drops the next cycle; 4 gap half-bits follow, then aborted=1 for 1 cycle.
  -> done stays 0; a later frame transmits normally.
- reset=0 for 1 cycle mid-DATA.
  -> all outputs return to reset values the next cycle; no done or aborted pulse.
